// File: rtl/control_decode_queue.sv
// Decoding instruction queue: decodes RV32I instructions at the input, stores them in a small FIFO,
// and presents the oldest entry at the head. Optional macro RV32M_EN adds M-extension (mdu_en/mdu_op).
module control_decode_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PC_W  = 32,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [PC_W-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             flush,
  output logic             reg_write,
  output logic             mem_en,
  output logic             l,
  output logic             sb,
  output logic             uj,
  output logic             jalr_i,
  output logic             u_aui,
  output logic             u_lui,
  output logic             operand_a,
  output logic             operand_b,
  output logic [1:0]       mem_reg,
  output logic [2:0]       imm_sel,
  output logic [3:0]       alu_control,
  output logic [2:0]       func3,
  output logic [4:0]       rd,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic             illegal,
  output logic [PC_W-1:0]  out_pc,
`ifdef RV32M_EN
  output logic             mdu_en,
  output logic [2:0]       mdu_op,
`endif
  output logic [CNT_W-1:0] count,
  output logic [15:0]      illegal_cnt
);

  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two in 2..16");
  end

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  typedef struct packed {
    logic            reg_write;
    logic            mem_en;
    logic            l;
    logic            sb;
    logic            uj;
    logic            jalr_i;
    logic            u_aui;
    logic            u_lui;
    logic            operand_a;
    logic            operand_b;
    logic [1:0]      mem_reg;
    logic [2:0]      imm_sel;
    logic [3:0]      alu_control;
    logic [2:0]      func3;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            illegal;
`ifdef RV32M_EN
    logic            mdu_en;
    logic [2:0]      mdu_op;
`endif
    logic [PC_W-1:0] pc;
  } entry_t;

  logic [6:0] opc;
  logic [6:0] f7;
  logic [2:0] f3;
  logic [3:0] alu_f;
  logic       bad;
  entry_t     dec_raw;
  entry_t     dec;

  assign opc = instr[6:0];
  assign f3  = instr[14:12];
  assign f7  = instr[31:25];

  // ALU op implied by func3 alone (add/srl variants; sub/sra chosen by funct7)
  always_comb begin
    alu_f = 4'b0000;
    case (f3)
      3'b000:  alu_f = 4'b0000;
      3'b001:  alu_f = 4'b0010;
      3'b010:  alu_f = 4'b0011;
      3'b011:  alu_f = 4'b0100;
      3'b100:  alu_f = 4'b0101;
      3'b101:  alu_f = 4'b0110;
      3'b110:  alu_f = 4'b1000;
      default: alu_f = 4'b1001;
    endcase
  end

  always_comb begin
    dec_raw       = '0;
    dec_raw.func3 = f3;
    dec_raw.rd    = instr[11:7];
    dec_raw.rs1   = instr[19:15];
    dec_raw.rs2   = instr[24:20];
    dec_raw.pc    = in_pc;
    bad           = (instr[1:0] != 2'b11);
    case (opc)
      OP_R: begin
        dec_raw.reg_write = 1'b1;
        case (f7)
          7'b0000000: dec_raw.alu_control = alu_f;
          7'b0100000: begin
            if (f3 == 3'b000)      dec_raw.alu_control = 4'b0001;
            else if (f3 == 3'b101) dec_raw.alu_control = 4'b0111;
            else                   bad = 1'b1;
          end
`ifdef RV32M_EN
          7'b0000001: begin
            dec_raw.mdu_en = 1'b1;
            dec_raw.mdu_op = f3;
          end
`endif
          default: bad = 1'b1;
        endcase
      end
      OP_I: begin
        dec_raw.reg_write   = 1'b1;
        dec_raw.operand_b   = 1'b1;
        dec_raw.alu_control = alu_f;
        if (f3 == 3'b001 && f7 != 7'b0000000) bad = 1'b1;
        if (f3 == 3'b101) begin
          if (f7 == 7'b0100000)      dec_raw.alu_control = 4'b0111;
          else if (f7 != 7'b0000000) bad = 1'b1;
        end
      end
      OP_LOAD: begin
        dec_raw.reg_write = 1'b1;
        dec_raw.l         = 1'b1;
        dec_raw.operand_b = 1'b1;
        dec_raw.mem_reg   = 2'b01;
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) bad = 1'b1;
      end
      OP_STORE: begin
        dec_raw.mem_en    = 1'b1;
        dec_raw.operand_b = 1'b1;
        dec_raw.imm_sel   = 3'b001;
        if (f3 > 3'b010) bad = 1'b1;
      end
      OP_BR: begin
        dec_raw.sb        = 1'b1;
        dec_raw.operand_a = 1'b1;
        dec_raw.operand_b = 1'b1;
        dec_raw.imm_sel   = 3'b010;
        if (f3 == 3'b010 || f3 == 3'b011) bad = 1'b1;
      end
      OP_JAL: begin
        dec_raw.reg_write = 1'b1;
        dec_raw.uj        = 1'b1;
        dec_raw.operand_a = 1'b1;
        dec_raw.operand_b = 1'b1;
        dec_raw.imm_sel   = 3'b011;
        dec_raw.mem_reg   = 2'b10;
      end
      OP_JALR: begin
        dec_raw.reg_write = 1'b1;
        dec_raw.jalr_i    = 1'b1;
        dec_raw.operand_b = 1'b1;
        if (f3 != 3'b000) bad = 1'b1;
      end
      OP_AUIPC: begin
        dec_raw.reg_write = 1'b1;
        dec_raw.u_aui     = 1'b1;
        dec_raw.operand_a = 1'b1;
        dec_raw.operand_b = 1'b1;
        dec_raw.imm_sel   = 3'b100;
      end
      OP_LUI: begin
        dec_raw.reg_write   = 1'b1;
        dec_raw.u_lui       = 1'b1;
        dec_raw.operand_b   = 1'b1;
        dec_raw.imm_sel     = 3'b100;
        dec_raw.alu_control = 4'b1010;
      end
      default: bad = 1'b1;
    endcase
  end

  // Illegal entries carry only their register fields and pc; all control is squashed
  always_comb begin
    dec = dec_raw;
    if (bad) begin
      dec         = '0;
      dec.func3   = dec_raw.func3;
      dec.rd      = dec_raw.rd;
      dec.rs1     = dec_raw.rs1;
      dec.rs2     = dec_raw.rs2;
      dec.pc      = dec_raw.pc;
      dec.illegal = 1'b1;
    end
  end

  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [15:0]        ill_cnt_q, ill_cnt_d;
  logic               in_ready_q;
  logic               out_valid_q;
  logic               push;
  logic               pop;

  assign push = in_valid && in_ready_q;
  assign pop  = out_valid_q && out_ready;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    ill_cnt_d = ill_cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      if (push && dec.illegal && ill_cnt_q != 16'hFFFF) ill_cnt_d = ill_cnt_q + 16'd1;
    end
  end

  // Ready/valid are registered copies of the next occupancy so neither depends on out_ready
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ill_cnt_q   <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ill_cnt_q   <= ill_cnt_d;
      in_ready_q  <= (count_d != CNT_W'(DEPTH));
      out_valid_q <= (count_d != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= dec;
  end

  entry_t head;
  assign head = mem_q[rd_ptr_q];

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign count       = count_q;
  assign illegal_cnt = ill_cnt_q;
  assign reg_write   = head.reg_write;
  assign mem_en      = head.mem_en;
  assign l           = head.l;
  assign sb          = head.sb;
  assign uj          = head.uj;
  assign jalr_i      = head.jalr_i;
  assign u_aui       = head.u_aui;
  assign u_lui       = head.u_lui;
  assign operand_a   = head.operand_a;
  assign operand_b   = head.operand_b;
  assign mem_reg     = head.mem_reg;
  assign imm_sel     = head.imm_sel;
  assign alu_control = head.alu_control;
  assign func3       = head.func3;
  assign rd          = head.rd;
  assign rs1         = head.rs1;
  assign rs2         = head.rs2;
  assign illegal     = head.illegal;
  assign out_pc      = head.pc;
`ifdef RV32M_EN
  assign mdu_en      = head.mdu_en;
  assign mdu_op      = head.mdu_op;
`endif

endmodule

// File: tb/tb_control_decode_queue.sv
// Scoreboard bench for control_decode_queue: expected decodes are queued on accepted pushes and
// compared at each pop; occupancy, flush and reset behaviour checked directly in each scenario task.
module tb_control_decode_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned PC_W  = 32;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned N_TBL = 15;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      instr;
  logic [PC_W-1:0]  in_pc;
  logic             out_valid;
  logic             out_ready;
  logic             flush;
  logic             reg_write, mem_en, l, sb, uj, jalr_i, u_aui, u_lui, operand_a, operand_b;
  logic [1:0]       mem_reg;
  logic [2:0]       imm_sel;
  logic [3:0]       alu_control;
  logic [2:0]       func3;
  logic [4:0]       rd, rs1, rs2;
  logic             illegal;
  logic [PC_W-1:0]  out_pc;
`ifdef RV32M_EN
  logic             mdu_en;
  logic [2:0]       mdu_op;
`endif
  logic [CNT_W-1:0] count;
  logic [15:0]      illegal_cnt;

  control_decode_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .flush(flush),
    .reg_write(reg_write), .mem_en(mem_en), .l(l), .sb(sb), .uj(uj), .jalr_i(jalr_i),
    .u_aui(u_aui), .u_lui(u_lui), .operand_a(operand_a), .operand_b(operand_b),
    .mem_reg(mem_reg), .imm_sel(imm_sel), .alu_control(alu_control), .func3(func3),
    .rd(rd), .rs1(rs1), .rs2(rs2), .illegal(illegal), .out_pc(out_pc),
`ifdef RV32M_EN
    .mdu_en(mdu_en), .mdu_op(mdu_op),
`endif
    .count(count), .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  // en = {reg_write, mem_en, l, sb, uj, jalr_i, u_aui, u_lui}
  typedef struct packed {
    logic [31:0]     instr;
    logic [PC_W-1:0] pc;
    logic            ill;
    logic [7:0]      en;
    logic            opa;
    logic            opb;
    logic [1:0]      mr;
    logic [2:0]      isel;
    logic [3:0]      alu;
    logic            mdu;
  } exp_t;

  exp_t        tbl [N_TBL];
  exp_t        sb_q [$];
  exp_t        cur_exp;
  exp_t        mon_e;
  int          checks = 0;
  int          failures = 0;
  int          exp_ill = 0;
  int          pc_n = 0;
  int          mon_cycles = 0;
  bit          done = 1'b0;
  logic [19:0] got_ctl, exp_ctl;
  logic [17:0] got_reg, exp_reg;

  function automatic exp_t mk(input logic [31:0] i, input logic ill, input logic [7:0] en,
                              input logic opa, input logic opb, input logic [1:0] mr,
                              input logic [2:0] isel, input logic [3:0] alu, input logic mdu);
    exp_t e;
    e.instr = i; e.pc = '0; e.ill = ill; e.en = en; e.opa = opa; e.opb = opb;
    e.mr = mr; e.isel = isel; e.alu = alu; e.mdu = mdu;
    return e;
  endfunction

  task automatic init_table();
    tbl[0]  = mk(32'h00208033, 0, 8'b1000_0000, 0, 0, 2'b00, 3'b000, 4'b0000, 0); // add
    tbl[1]  = mk(32'h40208033, 0, 8'b1000_0000, 0, 0, 2'b00, 3'b000, 4'b0001, 0); // sub
    tbl[2]  = mk(32'hFFFFFFFF, 1, 8'b0000_0000, 0, 0, 2'b00, 3'b000, 4'b0000, 0);
    tbl[3]  = mk(32'h12345037, 0, 8'b1000_0001, 0, 1, 2'b00, 3'b100, 4'b1010, 0); // lui
    tbl[4]  = mk(32'h00002083, 0, 8'b1010_0000, 0, 1, 2'b01, 3'b000, 4'b0000, 0); // lw
    tbl[5]  = mk(32'h0020A223, 0, 8'b0100_0000, 0, 1, 2'b00, 3'b001, 4'b0000, 0); // sw
    tbl[6]  = mk(32'h00208063, 0, 8'b0001_0000, 1, 1, 2'b00, 3'b010, 4'b0000, 0); // beq
    tbl[7]  = mk(32'h000000EF, 0, 8'b1000_1000, 1, 1, 2'b10, 3'b011, 4'b0000, 0); // jal
    tbl[8]  = mk(32'h000100E7, 0, 8'b1000_0100, 0, 1, 2'b00, 3'b000, 4'b0000, 0); // jalr
    tbl[9]  = mk(32'h00000097, 0, 8'b1000_0010, 1, 1, 2'b00, 3'b100, 4'b0000, 0); // auipc
    tbl[10] = mk(32'h4030D093, 0, 8'b1000_0000, 0, 1, 2'b00, 3'b000, 4'b0111, 0); // srai
    tbl[11] = mk(32'h0010C093, 0, 8'b1000_0000, 0, 1, 2'b00, 3'b000, 4'b0101, 0); // xori
    tbl[12] = mk(32'h00003083, 1, 8'b0000_0000, 0, 0, 2'b00, 3'b000, 4'b0000, 0); // load f3=011
    tbl[13] = mk(32'h0020A063, 1, 8'b0000_0000, 0, 0, 2'b00, 3'b000, 4'b0000, 0); // branch f3=010
`ifdef RV32M_EN
    tbl[14] = mk(32'h022080B3, 0, 8'b1000_0000, 0, 0, 2'b00, 3'b000, 4'b0000, 1); // mul
`else
    tbl[14] = mk(32'h022080B3, 1, 8'b0000_0000, 0, 0, 2'b00, 3'b000, 4'b0000, 0);
`endif
  endtask

  task automatic drive(input int idx);
    instr   = tbl[idx].instr;
    in_pc   = 32'h1000 + 32'(pc_n * 4);
    cur_exp = tbl[idx];
    cur_exp.pc = in_pc;
    pc_n++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(output bit ok);
    ok = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (count == '0) begin ok = 1'b1; break; end
      step();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; instr = '0; in_pc = '0;
    repeat (3) step();
    @(negedge clk);
    checks++;
    if (count !== '0 || out_valid !== 1'b0 || in_ready !== 1'b0 || illegal_cnt !== 16'd0) begin
      failures++;
      $display("FAIL reset_state count=%0d out_valid=%b in_ready=%b illegal_cnt=%0d want 0/0/0/0",
               count, out_valid, in_ready, illegal_cnt);
    end
    step();
    rst = 1'b1;
    step();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_first_latency();
    drive(0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || count !== CNT_W'(1)) begin
      failures++;
      $display("FAIL first_latency out_valid=%b count=%0d want 1/1", out_valid, count);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || count !== '0) begin
      failures++;
      $display("FAIL first_pop out_valid=%b count=%0d want 0/0", out_valid, count);
    end
  endtask

  task automatic test_decode_stream();
    bit ok;
    out_ready = 1'b1;
    for (int i = 0; i < int'(N_TBL); i++) begin
      drive(i);
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    drain(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL stream_drain count=%0d want 0", count); end
    checks++;
    if (illegal_cnt !== 16'(exp_ill)) begin
      failures++;
      $display("FAIL stream_illegal_cnt got=%0d want=%0d", illegal_cnt, exp_ill);
    end
  endtask

  task automatic test_full();
    bit ok;
    out_ready = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      drive(i + 3);
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || count !== CNT_W'(DEPTH) || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL full_state in_ready=%b count=%0d out_valid=%b want 0/%0d/1",
               in_ready, count, out_valid, DEPTH);
    end
    drive(10);
    in_valid = 1'b1;
    repeat (2) step();
    checks++;
    if (count !== CNT_W'(DEPTH)) begin
      failures++;
      $display("FAIL full_push_ignored count=%0d want %0d", count, DEPTH);
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (count !== CNT_W'(DEPTH - 1) || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL full_pop_with_push count=%0d in_ready=%b want %0d/1", count, in_ready, DEPTH - 1);
    end
    drain(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL full_drain count=%0d want 0", count); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(i + 6);
      in_valid = 1'b1;
      step();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(i % int'(N_TBL));
      step();
      checks++;
      if (count !== CNT_W'(2)) begin
        failures++;
        $display("FAIL b2b_count cycle=%0d got=%0d want 2", i, count);
      end
    end
    in_valid = 1'b0;
    drain(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL b2b_drain count=%0d want 0", count); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(0); in_valid = 1'b1; step();
    drive(2); step();
    drive(3); step();
    in_valid = 1'b0;
    checks++;
    if (count !== CNT_W'(3)) begin failures++; $display("FAIL flush_fill count=%0d want 3", count); end
    drive(2);
    in_valid = 1'b1;
    out_ready = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (count !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_empty count=%0d out_valid=%b in_ready=%b want 0/0/1", count, out_valid, in_ready);
    end
    checks++;
    if (illegal_cnt !== 16'(exp_ill)) begin
      failures++;
      $display("FAIL flush_illegal_cnt got=%0d want=%0d", illegal_cnt, exp_ill);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    out_ready = 1'b0;
    drive(2); in_valid = 1'b1; step();
    drive(4); step();
    in_valid = 1'b0;
    rst = 1'b0;
    step();
    checks++;
    if (count !== '0 || out_valid !== 1'b0 || in_ready !== 1'b0 || illegal_cnt !== 16'd0) begin
      failures++;
      $display("FAIL midreset count=%0d out_valid=%b in_ready=%b illegal_cnt=%0d want 0/0/0/0",
               count, out_valid, in_ready, illegal_cnt);
    end
    rst = 1'b1;
    step();
    drive(5);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    drain(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL midreset_drain count=%0d want 0", count); end
  endtask

  initial begin
    init_table();
    fork
      begin
        test_reset();
        test_first_latency();
        test_decode_stream();
        test_full();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        repeat (2) step();
        done = 1'b1;
      end
      begin
        // Scoreboard: sample at negedge, where the handshake about to be taken is stable
        while (!done) begin
          @(negedge clk);
          mon_cycles++;
          if (mon_cycles > 5000) begin
            failures++;
            $display("FAIL watchdog cycles=%0d limit=5000", mon_cycles);
            $fatal(1, "watchdog expired");
          end
          if (!rst) begin
            sb_q.delete();
            exp_ill = 0;
          end else if (flush) begin
            sb_q.delete();
          end else begin
            if (out_valid && out_ready) begin
              checks++;
              if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL pop_unexpected out_pc=%h want no output", out_pc);
              end else begin
                mon_e = sb_q.pop_front();
                got_ctl = {illegal, reg_write, mem_en, l, sb, uj, jalr_i, u_aui, u_lui,
                           operand_a, operand_b, mem_reg, imm_sel, alu_control};
                exp_ctl = {mon_e.ill, mon_e.en, mon_e.opa, mon_e.opb, mon_e.mr, mon_e.isel, mon_e.alu};
                if (got_ctl !== exp_ctl) begin
                  failures++;
                  $display("FAIL decode_ctl instr=%h got=%b want=%b", mon_e.instr, got_ctl, exp_ctl);
                end
                checks++;
                if (out_pc !== mon_e.pc) begin
                  failures++;
                  $display("FAIL order_pc instr=%h got=%h want=%h", mon_e.instr, out_pc, mon_e.pc);
                end
                if (!mon_e.ill) begin
                  checks++;
                  got_reg = {rd, rs1, rs2, func3};
                  exp_reg = {mon_e.instr[11:7], mon_e.instr[19:15], mon_e.instr[24:20], mon_e.instr[14:12]};
                  if (got_reg !== exp_reg) begin
                    failures++;
                    $display("FAIL decode_regs instr=%h got=%h want=%h", mon_e.instr, got_reg, exp_reg);
                  end
                end
`ifdef RV32M_EN
                checks++;
                if (mdu_en !== mon_e.mdu || (mon_e.mdu && mdu_op !== mon_e.instr[14:12])) begin
                  failures++;
                  $display("FAIL mdu instr=%h mdu_en=%b mdu_op=%b want en=%b", mon_e.instr, mdu_en, mdu_op, mon_e.mdu);
                end
`endif
              end
            end
            if (in_valid && in_ready) begin
              sb_q.push_back(cur_exp);
              if (cur_exp.ill) exp_ill++;
            end
          end
        end
      end
    join
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL leftover_entries got=%0d want 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/control_decode_queue.md
CONTROL_DECODE_QUEUE -- requirements
Module: control_decode_queue

Interface
REQ-001 Parameter DEPTH, default 4, queue entries; SHALL be a power of two, 2..16.
REQ-002 Parameter PC_W, default 32, width of the carried program counter.
REQ-003 clk  input  1  single clock; all state SHALL update on rising edge.
REQ-004 rst  input  1  synchronous, active-low reset.
REQ-005 in_valid  input  1  / in_ready  output  1  / instr  input  32  / in_pc  input  PC_W  upstream handshake and fetched instruction.
REQ-006 out_valid  output  1  / out_ready  input  1  downstream handshake.
REQ-007 flush  input  1  discards all queued entries.
REQ-008 Decoded head outputs SHALL be: reg_write, mem_en, l, sb, uj, jalr_i, u_aui, u_lui, operand_a, operand_b (1 each); mem_reg 2; imm_sel 3; alu_control 4; func3 3; rd, rs1, rs2 5 each; illegal 1; out_pc PC_W.
REQ-009 count  output  $clog2(DEPTH)+1  occupied entries; illegal_cnt  output  16  illegal instructions accepted.

Function
REQ-010 Push SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-011 in_ready SHALL be (count != DEPTH), registered-state only, with no combinational path from out_ready.
REQ-012 out_valid SHALL be (count != 0); outputs SHALL reflect the head entry and hold stable while out_valid && !out_ready.
REQ-013 Latency: instruction pushed at edge N SHALL be visible at the head from edge N+1 when the queue was empty.
REQ-014 Decode SHALL occur before storage; opcodes: R 0110011, I 0010011, load 0000011, store 0100011, branch 1100011, jal 1101111, jalr 1100111, auipc 0010111, lui 0110111.
REQ-015 reg_write SHALL be 1 for R, I, load, jal, jalr, auipc, lui; mem_en = store; l = load; sb = branch; uj = jal; jalr_i = jalr; u_aui = auipc; u_lui = lui.
REQ-016 operand_b SHALL be 1 for all valid types except R; operand_a SHALL be 1 for branch, jal, auipc.
REQ-017 imm_sel SHALL be: I/load/jalr 000, store 001, branch 010, jal 011, auipc/lui 100; R 000.
REQ-018 mem_reg SHALL be 01 for load, 10 for jal, 00 otherwise.
REQ-019 alu_control (R/I by func3, func7 bit = instr[30]): add 0000, sub 0001, sll 0010, slt 0011, sltu 0100, xor 0101, srl 0110, sra 0111, or 1000, and 1001; sub R-type only; load/store/branch/jal/jalr/auipc 0000; lui 1010 (pass operand B).
REQ-020 illegal SHALL be 1 for: instr[1:0]!=11; unknown opcode; R funct7 not 0000000/0100000 (or 0000001 per REQ-029); funct7 0100000 with func3 not 000/101; I-shift funct7 invalid; store func3>010; load func3 011/110/111; branch func3 010/011; jalr func3!=000.
REQ-021 Illegal entries SHALL be queued with every enable and reg_write/mem_en at 0, alu_control 0000, illegal 1.
REQ-022 Full with simultaneous push attempt: no push (in_ready=0); pop proceeds, count decrements.
REQ-023 Simultaneous push and pop with 0<count<DEPTH: count unchanged, order preserved.
REQ-024 Pointers SHALL wrap modulo DEPTH without loss.
REQ-025 flush SHALL empty the queue next edge, overriding same-cycle push and pop; illegal_cnt unaffected by flush; a pushed illegal instruction in a flush cycle SHALL NOT be counted.
REQ-026 illegal_cnt SHALL increment per accepted illegal push and saturate at 16'hFFFF.

Reset
REQ-027 While rst=0 at an edge: count=0, pointers=0, illegal_cnt=0, out_valid=0; in_ready SHALL read 0 during reset and 1 the first cycle after.
REQ-028 Reset mid-operation SHALL discard all entries; stored data contents are don't-care.

Configuration
REQ-029 Macro RV32M_EN: when defined, R-type funct7 0000001 SHALL decode legal, add outputs mdu_en (1) and mdu_op (3, = func3), with alu_control 0000; when undefined, those ports SHALL be absent and funct7 0000001 SHALL be illegal.

Verification
REQ-030 Reset, push 0x00208033 (add x0,x1,x2) -> next cycle out_valid=1, reg_write=1, alu_control=0000, operand_b=0, rs1=1, rs2=2.
REQ-031 out_ready=0, push DEPTH instructions -> in_ready=0, count=DEPTH; further push ignored; release -> original order drains.
REQ-032 Push 0xFFFFFFFF -> illegal=1, reg_write=0, mem_en=0, illegal_cnt=1.
REQ-033 Push 0x12345037 (lui) -> u_lui=1, imm_sel=100, alu_control=1010; 0x00002083 (lw) -> l=1, mem_reg=01.
REQ-034 Queue at count 3, flush with in_valid=1 -> count=0 next edge, out_valid=0.
REQ-035 With RV32M_EN, push 0x022080B3 (mul) -> mdu_en=1, mdu_op=000, illegal=0; without -> illegal=1.
